// File: rtl/bcd_decade_counter.sv
// rtl/bcd_decade_counter.sv - free-running mod-MODULUS BCD digit counter
// Async-clear, sync-release; the release edge itself never counts.

module bcd_decade_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic             r_run_en;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // Any value at or past the last digit (including corrupted ones) returns to 0.
  always_comb begin
    w_count_nxt = r_count + LP_ONE;
    if (r_count >= LP_LAST) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_en <= 1'b0;
      r_count  <= '0;
    end else begin
      r_run_en <= 1'b1;
      if (r_run_en) begin
        r_count <= w_count_nxt;
      end
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_bcd_decade_counter.sv
// tb/tb_bcd_decade_counter.sv - self-checking bench for bcd_decade_counter
// Reference: expected digit = (edges since release - 1) mod 10, 0 while in reset.

module tb_bcd_decade_counter;

  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_edges = 0;

  always #5 clk = ~clk;

  bcd_decade_counter #(
    .WIDTH   (4),
    .MODULUS (MOD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count)
  );

  function automatic logic [3:0] model_val();
    if (n_edges == 0) return 4'd0;
    return 4'((n_edges - 1) % MOD);
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Advance one rising edge, update the reference, then sample at the falling edge.
  task automatic step_check(input string tag);
    @(posedge clk);
    if (rst) n_edges++;
    #5;
    chk(tag, count, model_val());
  endtask

  initial begin
    int k;
    int h;
    rst = 1'b0;
    #20;
    chk("reset", count, 4'd0);
    rst = 1'b1;

    step_check("release_latency");
    for (int i = 1; i < 10; i++) step_check("count_up");
    step_check("wrap");
    for (int i = 0; i < 20; i++) step_check("continuous");

    // Mid-cycle async assert: count must clear before the next rising edge.
    #3;
    rst = 1'b0;
    n_edges = 0;
    #1;
    chk("async_mid", count, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    step_check("rerelease_edge");
    step_check("rerelease_first");

    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(3, 35);
      for (int i = 0; i < k; i++) step_check("rand_run");
      #($urandom_range(1, 3));
      rst = 1'b0;
      n_edges = 0;
      #1;
      chk("rand_async", count, 4'd0);
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) step_check("rand_hold");
      @(negedge clk);
      rst = 1'b1;
      step_check("rand_release");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
